node_ejector: RTL and testbench

- Terminal sink for the serialized 82-bit packet interface driven by a router node's xpos/ypos output ports.
- Captures valid packets from both ports each cycle into a shared FIFO. The FIFO accepts two writes per cycle.
- Presents packets to the local host/PE over a valid/ready interface.
- Counts packets lost to overflow, since the serial ports have no backpressure.

---
 rtl/node_pkg.sv | 22 ++
 rtl/node_ejector_if.sv | 25 ++
 rtl/ejector_fifo2w.sv | 53 +++++
 rtl/node_ejector.sv | 123 ++++++++++++
 tb/tb_node_ejector.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
// Shared definitions for the router node ejector: packet field positions,
// port identifiers and a small sequence-number helper.
package node_pkg;

    localparam int PKT_W     = 82;
    localparam int VALID_BIT = 81;
    localparam int SEQ_LSB   = 0;
    localparam int SEQ_MSB   = 7;
    localparam int SEQ_W     = SEQ_MSB - SEQ_LSB + 1;

    typedef enum logic {
        PORT_XPOS = 1'b0,
        PORT_YPOS = 1'b1
    } port_id_e;

    // A port's sequence numbers count down by one per packet, wrapping 0 -> 255.
    function automatic logic seq_follows(input logic [SEQ_W-1:0] cur,
                                         input logic [SEQ_W-1:0] prev);
        return cur == (prev - 8'd1);
    endfunction

endpackage

// File: rtl/node_ejector_if.sv
// Host-side valid/ready packet interface of the node ejector.
// master = packet source (the ejector), slave = packet sink (host/PE).
interface node_ejector_if #(
    parameter int PKT_W = 82
);
    logic             out_valid;
    logic             out_ready;
    logic [PKT_W-1:0] out_pkt;
    logic             out_port;

    modport master (
        output out_valid,
        output out_pkt,
        output out_port,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pkt,
        input  out_port,
        output out_ready
    );

endinterface

// File: rtl/ejector_fifo2w.sv
// Two-write / one-read FIFO used by the node ejector. The caller guarantees
// push_cnt never exceeds the free space; entry A is written before entry B.
module ejector_fifo2w #(
    parameter int DEPTH = 8,
    parameter int W     = 83
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 push_cnt,
    input  logic [W-1:0]               wr_data_a,
    input  logic [W-1:0]               wr_data_b,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_b;

    assign wr_ptr_b = wr_ptr + ONE_A;
    assign head     = mem[rd_ptr];

    // Storage array; deliberately not reset, contents only matter below count.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= wr_data_a;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr_b] <= wr_data_b;
        end
    end

    // Pointers and occupancy; a pop and up to two pushes may happen together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{(AW-2){1'b0}}, push_cnt};
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_A;
            end
            count <= count + {{(AW-1){1'b0}}, push_cnt} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/node_ejector.sv
// Terminal sink for a router node's xpos/ypos serial packet ports.
// Valid packets from both ports are captured every cycle into a shared
// 2-write FIFO (xpos first) and handed to the host over valid/ready.
// Packets that do not fit are dropped and counted (saturating).
// Optional: define EJECTOR_SEQ_CHECK_EN to enable the per-port sticky
// sequence-number checker driving seq_err; otherwise seq_err is 0.
module node_ejector #(
    parameter int DEPTH = 8,
    parameter int PKT_W = node_pkg::PKT_W,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PKT_W-1:0]     in_xpos_ser,
    input  logic [PKT_W-1:0]     in_ypos_ser,
    node_ejector_if.master       out_if,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [1:0]           seq_err
);

    import node_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

    logic             x_valid;
    logic             y_valid;
    logic [1:0]       n_valid;
    logic [1:0]       n_acc;
    logic [1:0]       n_drop;
    logic [AW:0]      count;
    logic [AW:0]      free;
    logic             pop;
    logic [PKT_W:0]   entry_a;
    logic [PKT_W:0]   entry_b;
    logic [PKT_W:0]   head;
    logic [CNT_W:0]   drop_sum;

    assign x_valid = in_xpos_ser[VALID_BIT];
    assign y_valid = in_ypos_ser[VALID_BIT];

    // Admission: free space is judged before this cycle's pop, xpos wins.
    always_comb begin
        n_valid = {1'b0, x_valid} + {1'b0, y_valid};
        free    = DEPTH_C - count;
        if (free >= {{(AW-1){1'b0}}, n_valid}) begin
            n_acc = n_valid;
        end else begin
            n_acc = free[1:0];
        end
        n_drop  = n_valid - n_acc;
        entry_a = x_valid ? {logic'(PORT_XPOS), in_xpos_ser}
                          : {logic'(PORT_YPOS), in_ypos_ser};
        entry_b = {logic'(PORT_YPOS), in_ypos_ser};
    end

    ejector_fifo2w #(
        .DEPTH (DEPTH),
        .W     (PKT_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_cnt  (n_acc),
        .wr_data_a (entry_a),
        .wr_data_b (entry_b),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_if.out_valid = (count != '0);
    assign out_if.out_pkt   = head[PKT_W-1:0];
    assign out_if.out_port  = head[PKT_W];
    assign pop              = out_if.out_valid && out_if.out_ready;

    assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, n_drop};

    // Overflow drop counter, clamps at its maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_sum[CNT_W]) begin
            drop_cnt <= DROP_MAX;
        end else begin
            drop_cnt <= drop_sum[CNT_W-1:0];
        end
    end

`ifdef EJECTOR_SEQ_CHECK_EN
    logic [SEQ_W-1:0] last_seq [2];
    logic [SEQ_W-1:0] cur_seq  [2];
    logic [1:0]       seen;
    logic [1:0]       port_valid;

    assign port_valid = {y_valid, x_valid};
    assign cur_seq[0] = in_xpos_ser[SEQ_MSB:SEQ_LSB];
    assign cur_seq[1] = in_ypos_ser[SEQ_MSB:SEQ_LSB];

    // Per-port sequence tracking; dropped packets still advance last_seq.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_seq[0] <= '0;
            last_seq[1] <= '0;
            seen        <= '0;
            seq_err     <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (port_valid[p]) begin
                    if (seen[p] && !seq_follows(cur_seq[p], last_seq[p])) begin
                        seq_err[p] <= 1'b1;
                    end
                    last_seq[p] <= cur_seq[p];
                    seen[p]     <= 1'b1;
                end
            end
        end
    end
`else
    assign seq_err = 2'b00;
`endif

endmodule

// File: tb/tb_node_ejector.sv
// Directed, table-driven bench for node_ejector (DEPTH=8). Each table row is
// one clock cycle: inputs driven after the falling edge, outputs checked just
// after, reflecting state before the coming rising edge.
module tb_node_ejector;

`ifdef EJECTOR_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [81:0] in_xpos_ser;
    logic [81:0] in_ypos_ser;
    logic [15:0] drop_cnt;
    logic [1:0]  seq_err;

    int n_vec;
    int n_err;

    node_ejector_if #(.PKT_W(82)) out_if ();

    node_ejector #(
        .DEPTH (8),
        .PKT_W (82),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_xpos_ser (in_xpos_ser),
        .in_ypos_ser (in_ypos_ser),
        .out_if      (out_if.master),
        .drop_cnt    (drop_cnt),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        xv;
        logic [7:0]  xs;
        logic        yv;
        logic [7:0]  ys;
        logic        rdy;
        logic        ev;
        logic        ep;
        logic [7:0]  es;
        logic [15:0] ed;
        logic [1:0]  ee;
    } vec_t;

    vec_t vq[$];

    // Port-specific payloads make a swapped port visible in out_pkt as well.
    function automatic logic [81:0] make_pkt(input logic v, input logic p, input logic [7:0] s);
        logic [72:0] pl;
        pl = p ? {9'h0C3, 64'h0123_4567_89AB_CDEF} : {9'h1A5, 64'hDEAD_BEEF_CAFE_F00D};
        return {v, pl, s};
    endfunction

    function automatic void add(input logic xv, input logic [7:0] xs,
                                input logic yv, input logic [7:0] ys,
                                input logic rdy, input logic ev,
                                input logic ep, input logic [7:0] es,
                                input logic [15:0] ed, input logic [1:0] ee);
        vec_t v;
        v.xv = xv; v.xs = xs; v.yv = yv; v.ys = ys; v.rdy = rdy;
        v.ev = ev; v.ep = ep; v.es = es; v.ed = ed;
        v.ee = SEQ_EN ? ee : 2'b00;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [81:0] act, input logic [81:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        in_xpos_ser      = make_pkt(v.xv, 1'b0, v.xs);
        in_ypos_ser      = make_pkt(v.yv, 1'b1, v.ys);
        out_if.out_ready = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #1;
        n_vec++;
        chk("out_valid", idx, 82'(out_if.out_valid), 82'(v.ev));
        chk("drop_cnt",  idx, 82'(drop_cnt),         82'(v.ed));
        chk("seq_err",   idx, 82'(seq_err),          82'(v.ee));
        if (v.ev) begin
            chk("out_port", idx, 82'(out_if.out_port), 82'(v.ep));
            chk("out_pkt",  idx, out_if.out_pkt,       make_pkt(1'b1, v.ep, v.es));
        end
    endtask

    task automatic runTable();
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i]);
            checkOutput(vq[i], i);
        end
        vq.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst              = 1'b1;
        in_xpos_ser      = '0;
        in_ypos_ser      = '0;
        out_if.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_vec            = 0;
        n_err            = 0;
        rst              = 1'b0;
        in_xpos_ser      = '0;
        in_ypos_ser      = '0;
        out_if.out_ready = 1'b0;

        // Interleaved streaming: x6,y6,x5,y5,... with host always ready.
        doReset();
        //   xv xs  yv ys  rdy ev ep es d  err
        add(1, 6,  1, 6,  1,  0, 0, 0, 0, 2'b00);
        add(1, 5,  1, 5,  1,  1, 0, 6, 0, 2'b00);
        add(1, 4,  1, 4,  1,  1, 1, 6, 0, 2'b00);
        add(1, 3,  1, 3,  1,  1, 0, 5, 0, 2'b00);
        add(0, 0,  0, 0,  1,  1, 1, 5, 0, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 4, 0, 2'b00);
        add(0, 0,  0, 0,  1,  1, 1, 4, 0, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 3, 0, 2'b00);
        add(0, 0,  0, 0,  1,  1, 1, 3, 0, 2'b00);
        add(0, 0,  0, 0,  1,  0, 0, 0, 0, 2'b00);
        runTable();

        // Overflow with host stalled, then count=7 push(2)+pop, then drain.
        doReset();
        add(1, 6,  1, 6,  0,  0, 0, 0, 0, 2'b00);
        add(1, 5,  1, 5,  0,  1, 0, 6, 0, 2'b00);
        add(1, 4,  1, 4,  0,  1, 0, 6, 0, 2'b00);
        add(1, 3,  1, 3,  0,  1, 0, 6, 0, 2'b00);
        add(1, 2,  1, 2,  0,  1, 0, 6, 0, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 6, 2, 2'b00);
        add(1, 1,  1, 1,  1,  1, 1, 6, 2, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 5, 3, 2'b00);
        add(0, 0,  0, 0,  1,  1, 1, 5, 3, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 4, 3, 2'b00);
        add(0, 0,  0, 0,  1,  1, 1, 4, 3, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 3, 3, 2'b00);
        add(0, 0,  0, 0,  1,  1, 1, 3, 3, 2'b00);
        add(0, 0,  0, 0,  1,  1, 0, 1, 3, 2'b00);
        add(0, 0,  0, 0,  1,  0, 0, 0, 3, 2'b00);
        // Sequence checks: x 0,255 wrap is legal, then 253 is an error;
        // y 0,255 wrap stays clean. Then load 4 packets for the reset test.
        add(1, 0,   0, 0,   1, 0, 0, 0,   3, 2'b00);
        add(1, 255, 0, 0,   1, 1, 0, 0,   3, 2'b00);
        add(1, 253, 0, 0,   1, 1, 0, 255, 3, 2'b00);
        add(0, 0,   1, 0,   1, 1, 0, 253, 3, 2'b01);
        add(0, 0,   1, 255, 1, 1, 1, 0,   3, 2'b01);
        add(0, 0,   0, 0,   1, 1, 1, 255, 3, 2'b01);
        add(0, 0,   0, 0,   1, 0, 0, 0,   3, 2'b01);
        add(1, 252, 1, 254, 0, 0, 0, 0,   3, 2'b01);
        add(1, 251, 1, 253, 0, 1, 0, 252, 3, 2'b01);
        runTable();

        // Asynchronous reset with 4 packets stored.
        @(negedge clk);
        in_xpos_ser      = make_pkt(1'b0, 1'b0, 8'h11);
        in_ypos_ser      = make_pkt(1'b0, 1'b1, 8'h22);
        out_if.out_ready = 1'b0;
        #1;
        n_vec++;
        chk("pre_reset_valid", 100, 82'(out_if.out_valid), 82'(1));
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        chk("async_rst_valid", 101, 82'(out_if.out_valid), 82'(0));
        chk("async_rst_drop",  101, 82'(drop_cnt),         82'(0));
        chk("async_rst_err",   101, 82'(seq_err),          82'(0));
        @(negedge clk);
        rst         = 1'b0;
        in_xpos_ser = make_pkt(1'b1, 1'b0, 8'd7);
        #1;
        n_vec++;
        chk("post_rst_empty", 102, 82'(out_if.out_valid), 82'(0));
        @(negedge clk);
        in_xpos_ser = make_pkt(1'b0, 1'b0, 8'd7);
        #1;
        n_vec++;
        chk("post_rst_valid", 103, 82'(out_if.out_valid), 82'(1));
        chk("post_rst_port",  103, 82'(out_if.out_port),  82'(0));
        chk("post_rst_pkt",   103, out_if.out_pkt,        make_pkt(1'b1, 1'b0, 8'd7));

        // Pop the packet, then ten cycles of invalid inputs with payload.
        add(0, 0,    0, 0,    1, 1, 0, 7, 0, 2'b00);
        add(0, 8'h5A, 0, 8'hA5, 1, 0, 0, 0, 0, 2'b00);
        add(0, 8'h01, 0, 8'hFF, 0, 0, 0, 0, 0, 2'b00);
        add(0, 8'h33, 0, 8'h44, 1, 0, 0, 0, 0, 2'b00);
        add(0, 8'h80, 0, 8'h7F, 0, 0, 0, 0, 0, 2'b00);
        add(0, 8'h12, 0, 8'h34, 1, 0, 0, 0, 0, 2'b00);
        add(0, 8'hC3, 0, 8'h3C, 1, 0, 0, 0, 0, 2'b00);
        add(0, 8'h06, 0, 8'h05, 0, 0, 0, 0, 0, 2'b00);
        add(0, 8'hFE, 0, 8'hEF, 1, 0, 0, 0, 0, 2'b00);
        add(0, 8'h99, 0, 8'h66, 0, 0, 0, 0, 0, 2'b00);
        add(0, 8'h0F, 0, 8'hF0, 1, 0, 0, 0, 0, 2'b00);
        add(0, 0,    0, 0,    1, 0, 0, 0, 0, 2'b00);
        runTable();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
